// File: rtl/seq_mul_pkg.sv
// rtl/seq_mul_pkg.sv - shared types and helpers for the shift-add multiplier
// Contents:
//   state_e : controller states IDLE / CALC / DONE
//   MAG_W   : working width of mag(); operands up to MAG_W-1 bits are supported
//   mag()   : two's-complement magnitude of a sign-extended operand
package seq_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int MAG_W = 64;

   // The caller sign-extends its operand to MAG_W bits when signed.
   // The most-negative value maps to 2^(W-1). That value fits the unsigned
   // W-bit field once the caller truncates the result back to W bits.
   function automatic logic [MAG_W-1:0] mag(input logic [MAG_W-1:0] v, input logic s);
      return (s && v[MAG_W-1]) ? -v : v;
   endfunction

endpackage

// File: rtl/seq_mul_ctrl.sv
// rtl/seq_mul_ctrl.sv - FSM and bit counter for the shift-add multiplier
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : operation request, honoured in IDLE or DONE
//   zero       : either operand is zero (early exit)
//   load       : strobe, load operands and start CALC
//   shift      : strobe, retire one multiplier bit this edge
//   finish     : strobe, write the product register this edge
//   busy, done : registered status outputs
module seq_mul_ctrl
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic zero,
   output logic load,
   output logic shift,
   output logic finish,
   output logic busy,
   output logic done
);

   localparam int CW = $clog2(WIDTH);

   state_e          state;
   logic [CW-1:0]   cnt;
   logic            accept;
   logic            last;

   assign accept = start && (state == IDLE || state == DONE);
   assign last   = (cnt == CW'(WIDTH - 1));
   assign load   = accept && !zero;
   assign shift  = (state == CALC);
   // The early exit also writes product (as zero), so finish covers both paths.
   assign finish = (shift && last) || (accept && zero);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept && zero) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else if (accept) begin
                  state <= CALC;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end else begin
                  state <= IDLE;
                  done  <= 1'b0;
                  busy  <= 1'b0;
               end
            end
            CALC: begin
               cnt <= cnt + 1'b1;
               if (last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/seq_mul_shift_add.sv
// rtl/seq_mul_shift_add.sv - sequential shift-add multiplier, unsigned or signed
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request, accepted in IDLE or DONE
//   a, b        : multiplicand / multiplier, sampled on the accepting edge
//   signed_mode : 1 = two's-complement operands
//   busy        : high while calculating
//   done        : one-cycle pulse, product valid from this cycle
//   product     : 2*WIDTH result, held until the next result is written
// WIDTH must be at least 2 and below MAG_W.
module seq_mul_shift_add
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mq;
   logic [WIDTH-1:0]   hi;
   logic               neg;
   logic               load;
   logic               shift;
   logic               finish;
   logic               zero;
   logic [MAG_W-1:0]   a_ext;
   logic [MAG_W-1:0]   b_ext;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] nxt;
   logic [2*WIDTH-1:0] res;

   assign zero  = (a == '0) || (b == '0);
   assign a_ext = {{(MAG_W-WIDTH){signed_mode & a[WIDTH-1]}}, a};
   assign b_ext = {{(MAG_W-WIDTH){signed_mode & b[WIDTH-1]}}, b};

   // The upper half adds the multiplicand with its carry kept. Then
   // {carry, hi, mq} moves right one place, and mq's LSB drops out.
   assign sum = {1'b0, hi} + (mq[0] ? {1'b0, mcand} : '0);
   assign nxt = {sum, mq[WIDTH-1:1]};
   assign res = neg ? -nxt : nxt;

   seq_mul_ctrl #(.WIDTH(WIDTH)) u_ctrl (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .zero   (zero),
      .load   (load),
      .shift  (shift),
      .finish (finish),
      .busy   (busy),
      .done   (done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand   <= '0;
         mq      <= '0;
         hi      <= '0;
         neg     <= 1'b0;
         product <= '0;
      end else begin
         if (load) begin
            mcand <= WIDTH'(mag(a_ext, signed_mode));
            mq    <= WIDTH'(mag(b_ext, signed_mode));
            hi    <= '0;
            neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
         end else if (shift) begin
            {hi, mq} <= nxt;
         end
         // finish outside CALC is the zero-operand exit.
         if (finish)
            product <= shift ? res : '0;
      end
   end

endmodule

// File: tb/tb_seq_mul_shift_add.sv
// tb/tb_seq_mul_shift_add.sv - directed self-checking bench for seq_mul_shift_add
module tb_seq_mul_shift_add;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic        signed_mode = 1'b0;
   logic        busy;
   logic        done;
   logic [15:0] product;

   int compared = 0;
   int mismatched = 0;
   int overlap = 0;

   seq_mul_shift_add #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .a           (a),
      .b           (b),
      .signed_mode (signed_mode),
      .busy        (busy),
      .done        (done),
      .product     (product)
   );

   always #5 clk = ~clk;

   // Runs one operation. Edges are counted from the accepting edge E0 (1)
   // up to the edge after which done is seen. The task returns at the
   // falling edge inside the done cycle.
   task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic is,
                        input bit b2b, output int edges, output int bcyc,
                        output logic [15:0] p);
      if (!b2b) @(negedge clk);
      a = ia; b = ib; signed_mode = is; start = 1'b1;
      @(posedge clk);
      edges = 1;
      bcyc  = 0;
      @(negedge clk);
      start = 1'b0;
      while (!done && edges < 20) begin
         if (busy) bcyc++;
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (busy && done) overlap++;
      end
      p = product;
   endtask

   task automatic test_reset;
      compared++;
      if ({busy, done, product} !== 18'd0) begin
         mismatched++;
         $display("FAIL reset_outputs: got busy=%b done=%b product=%h, want 0 0 0000", busy, done, product);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_unsigned;
      int e, bc;
      logic [15:0] p;
      do_op(8'd13, 8'd11, 1'b0, 0, e, bc, p);
      compared++;
      if (e !== 9) begin mismatched++; $display("FAIL u13x11_latency: got %0d edges, want 9", e); end
      compared++;
      if (bc !== 8) begin mismatched++; $display("FAIL u13x11_busy: got %0d busy cycles, want 8", bc); end
      compared++;
      if (p !== 16'h008F) begin mismatched++; $display("FAIL u13x11_product: got %h, want 008f", p); end
      repeat (2) @(negedge clk);
      compared++;
      if ({busy, done, product} !== {2'b00, 16'h008F}) begin
         mismatched++;
         $display("FAIL u13x11_hold: got busy=%b done=%b product=%h, want 0 0 008f", busy, done, product);
      end
      do_op(8'hFF, 8'hFF, 1'b0, 0, e, bc, p);
      compared++;
      if (p !== 16'hFE01) begin mismatched++; $display("FAIL u255x255: got %h, want fe01", p); end
   endtask

   task automatic test_signed;
      int e, bc;
      logic [15:0] p;
      do_op(8'hFD, 8'd5, 1'b1, 0, e, bc, p);
      compared++;
      if (p !== 16'hFFF1) begin mismatched++; $display("FAIL s_m3x5: got %h, want fff1", p); end
      do_op(8'h80, 8'h80, 1'b1, 0, e, bc, p);
      compared++;
      if (p !== 16'h4000) begin mismatched++; $display("FAIL s_m128sq: got %h, want 4000", p); end
      compared++;
      if (e !== 9) begin mismatched++; $display("FAIL s_m128sq_latency: got %0d edges, want 9", e); end
   endtask

   task automatic test_zero;
      int e, bc;
      logic [15:0] p;
      do_op(8'd0, 8'd200, 1'b0, 0, e, bc, p);
      compared++;
      if (e !== 1 || bc !== 0 || p !== 16'h0000) begin
         mismatched++;
         $display("FAIL zero_a: got edges=%0d busy=%0d product=%h, want 1 0 0000", e, bc, p);
      end
      do_op(8'd77, 8'd0, 1'b1, 0, e, bc, p);
      compared++;
      if (e !== 1 || bc !== 0 || p !== 16'h0000) begin
         mismatched++;
         $display("FAIL zero_b: got edges=%0d busy=%0d product=%h, want 1 0 0000", e, bc, p);
      end
   endtask

   task automatic test_start_ignored;
      int e;
      @(negedge clk);
      a = 8'd13; b = 8'd11; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk);
      e = 1;
      @(negedge clk);
      start = 1'b0;
      while (!done && e < 20) begin
         if (e == 3) begin a = 8'd5; b = 8'd6; signed_mode = 1'b1; start = 1'b1; end
         else start = 1'b0;
         @(posedge clk);
         e++;
         @(negedge clk);
      end
      start = 1'b0;
      compared++;
      if (e !== 9 || product !== 16'h008F) begin
         mismatched++;
         $display("FAIL start_mid_calc: got edges=%0d product=%h, want 9 008f", e, product);
      end
   endtask

   task automatic test_back_to_back;
      int e, bc;
      logic [15:0] p;
      do_op(8'd6, 8'd7, 1'b0, 0, e, bc, p);
      compared++;
      if (p !== 16'h002A) begin mismatched++; $display("FAIL b2b_first: got %h, want 002a", p); end
      do_op(8'd10, 8'hFE, 1'b1, 1, e, bc, p);
      compared++;
      if (e !== 9 || bc !== 8 || p !== 16'hFFEC) begin
         mismatched++;
         $display("FAIL b2b_second: got edges=%0d busy=%0d product=%h, want 9 8 ffec", e, bc, p);
      end
   endtask

   task automatic test_reset_mid_calc;
      int e, bc;
      logic [15:0] p;
      @(negedge clk);
      a = 8'd13; b = 8'd11; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      compared++;
      if ({busy, done, product} !== 18'd0) begin
         mismatched++;
         $display("FAIL reset_mid_calc: got busy=%b done=%b product=%h, want 0 0 0000", busy, done, product);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_op(8'd7, 8'd9, 1'b0, 0, e, bc, p);
      compared++;
      if (e !== 9 || p !== 16'h003F) begin
         mismatched++;
         $display("FAIL after_reset_7x9: got edges=%0d product=%h, want 9 003f", e, p);
      end
   endtask

   initial begin
      #1;
      test_reset;
      test_unsigned;
      test_signed;
      test_zero;
      test_start_ignored;
      test_back_to_back;
      test_reset_mid_calc;
      compared++;
      if (overlap !== 0) begin
         mismatched++;
         $display("FAIL busy_done_overlap: got %0d cycles, want 0", overlap);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
